bus_tristate_arbiter: RTL and testbench

//  Parametrised multi-channel tri-state bus driver: CHANNELS requesters share one WIDTH-bit tri-state bus.

---
 rtl/bus_tristate_arbiter.sv | 140 ++++++++++++++
 tb/tb_bus_tristate_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_tristate_arbiter.sv
// Round-robin arbiter driving one shared tri-state bus from CHANNELS local requesters.
// Ownership is capped at BURST beats and followed by TURN+1 high-Z cycles before the next owner drives.
module bus_tristate_arbiter #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned BURST    = 4,
  parameter int unsigned TURN     = 1
) (
  input  logic                          Clk,
  input  logic                          Reset_n,
  input  logic [CHANNELS-1:0]           req,
  input  logic [CHANNELS*WIDTH-1:0]     data_in,
  output logic [CHANNELS-1:0]           grant,
  output logic [WIDTH-1:0]              bus,
  output logic                          bus_oe,
  output logic [$clog2(CHANNELS)-1:0]   owner
);

  localparam int unsigned OW = $clog2(CHANNELS);
  localparam int unsigned CW = $clog2(BURST + 1);
  localparam int unsigned TW = (TURN > 0) ? $clog2(TURN + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_TURN  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic [OW-1:0]   last_q, last_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [WIDTH-1:0] bus_q, bus_d;
  logic            oe_q, oe_d;

  logic [OW-1:0]   pick;
  logic            pick_vld;
  logic [OW-1:0]   idx;
  int unsigned     idx32;
  logic [CHANNELS-1:0] grant_w;
  logic [WIDTH-1:0] chan [CHANNELS];

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    assign chan[c] = data_in[c*WIDTH +: WIDTH];
  end

  // Round-robin pick: first requester after the last owner, wrapping.
  always_comb begin
    pick     = last_q;
    pick_vld = 1'b0;
    idx32    = 0;
    idx      = '0;
    for (int unsigned i = 1; i <= CHANNELS; i++) begin
      idx32 = (32'(last_q) + i) % CHANNELS;
      idx   = OW'(idx32);
      if (!pick_vld && req[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  // Next-state, grant and registered-output update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tcnt_d  = tcnt_q;
    last_d  = last_q;
    owner_d = owner_q;
    bus_d   = bus_q;
    oe_d    = oe_q;
    grant_w = '0;
    unique case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          grant_w[pick] = 1'b1;
          bus_d         = chan[pick];
          oe_d          = 1'b1;
          owner_d       = pick;
          cnt_d         = CW'(1);
          state_d       = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (req[owner_q] && (cnt_q < CW'(BURST))) begin
          grant_w[owner_q] = 1'b1;
          bus_d            = chan[owner_q];
          cnt_d            = cnt_q + CW'(1);
        end else begin
          oe_d   = 1'b0;
          last_d = owner_q;
          if (TURN > 0) begin
            tcnt_d  = TW'(TURN);
            state_d = S_TURN;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_TURN: begin
        tcnt_d = tcnt_q - TW'(1);
        if (tcnt_q == TW'(1)) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        oe_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tcnt_q  <= '0;
      last_q  <= OW'(CHANNELS - 1);
      owner_q <= '0;
      bus_q   <= '0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      bus_q   <= bus_d;
      oe_q    <= oe_d;
    end
  end

  // Grant is forced low while reset is held, whatever req does.
  assign grant  = Reset_n ? grant_w : '0;
  assign bus_oe = oe_q;
  assign owner  = owner_q;
  assign bus    = oe_q ? bus_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_bus_tristate_arbiter.sv
// Scoreboard bench: three arbiter configurations share one random stimulus stream;
// a queue-based reference model predicts every driven beat and every grant.
module tb_bus_tristate_arbiter;

  localparam int ND = 3;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] o;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [3:0]  req;
  logic [31:0] data_in;
  logic [3:0]  grant_a, grant_b;
  logic [1:0]  grant_c;
  wire  [7:0]  bus_a, bus_b, bus_c;
  logic        oe_a, oe_b, oe_c;
  logic [1:0]  owner_a, owner_b;
  logic        owner_c;

  always #5 Clk = ~Clk;

  bus_tristate_arbiter #(.WIDTH(8), .CHANNELS(4), .BURST(4), .TURN(1)) u_a (
    .Clk(Clk), .Reset_n(Reset_n), .req(req), .data_in(data_in),
    .grant(grant_a), .bus(bus_a), .bus_oe(oe_a), .owner(owner_a));

  bus_tristate_arbiter #(.WIDTH(8), .CHANNELS(4), .BURST(1), .TURN(0)) u_b (
    .Clk(Clk), .Reset_n(Reset_n), .req(req), .data_in(data_in),
    .grant(grant_b), .bus(bus_b), .bus_oe(oe_b), .owner(owner_b));

  bus_tristate_arbiter #(.WIDTH(8), .CHANNELS(2), .BURST(2), .TURN(0)) u_c (
    .Clk(Clk), .Reset_n(Reset_n), .req(req[1:0]), .data_in(data_in[15:0]),
    .grant(grant_c), .bus(bus_c), .bus_oe(oe_c), .owner(owner_c));

  int n_checks = 0;
  int n_pass   = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int holder   [ND];
  int beats    [ND];
  int hold_off [ND];
  int last     [ND];
  bit prev_oe  [ND];
  int prev_own [ND];

  function automatic int cfg_ch(input int k);
    return (k == 2) ? 2 : 4;
  endfunction

  function automatic int cfg_burst(input int k);
    return (k == 0) ? 4 : ((k == 1) ? 1 : 2);
  endfunction

  function automatic int cfg_turn(input int k);
    return (k == 0) ? 1 : 0;
  endfunction

  function automatic logic [3:0] dut_gnt(input int k);
    case (k)
      0:       return grant_a;
      1:       return grant_b;
      default: return {2'b00, grant_c};
    endcase
  endfunction

  function automatic logic dut_oe(input int k);
    case (k)
      0:       return oe_a;
      1:       return oe_b;
      default: return oe_c;
    endcase
  endfunction

  function automatic logic [7:0] dut_bus(input int k);
    case (k)
      0:       return bus_a;
      1:       return bus_b;
      default: return bus_c;
    endcase
  endfunction

  function automatic logic [1:0] dut_owner(input int k);
    case (k)
      0:       return owner_a;
      1:       return owner_b;
      default: return {1'b0, owner_c};
    endcase
  endfunction

  function automatic int q_size(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t q_pop(input int k);
    case (k)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  task automatic q_push(input int k, input exp_t e);
    case (k)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic chk(input bit ok, input string name, input int k, input int act, input int exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s dut%0d: got %0h expected %0h (t=%0t)", name, k, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int k = 0; k < ND; k++) begin
      holder[k]   = -1;
      beats[k]    = 0;
      hold_off[k] = 0;
      last[k]     = cfg_ch(k) - 1;
      prev_oe[k]  = 1'b0;
      prev_own[k] = 0;
    end
    q0.delete();
    q1.delete();
    q2.delete();
  endtask

  // Which channel the rules allow to hand over a beat this cycle.
  function automatic logic [3:0] model_grant(input int k);
    logic [3:0] g;
    int n;
    int c;
    g = 4'b0000;
    n = cfg_ch(k);
    if (holder[k] >= 0) begin
      if (req[holder[k]] && beats[k] < cfg_burst(k)) g[holder[k]] = 1'b1;
    end else if (hold_off[k] == 0) begin
      for (int i = 1; i <= n; i++) begin
        c = (last[k] + i) % n;
        if (g == 4'b0000 && req[c]) g[c] = 1'b1;
      end
    end
    return g;
  endfunction

  // Advance the model across one clock edge; every captured beat is queued for the monitor.
  task automatic model_edge(input int k);
    logic [3:0] g;
    exp_t e;
    g = model_grant(k);
    if (holder[k] >= 0) begin
      if (g != 4'b0000) begin
        e.d = data_in[holder[k]*8 +: 8];
        e.o = 2'(holder[k]);
        q_push(k, e);
        beats[k]++;
      end else begin
        last[k]     = holder[k];
        holder[k]   = -1;
        hold_off[k] = cfg_turn(k);
      end
    end else if (hold_off[k] > 0) begin
      hold_off[k]--;
    end else if (g != 4'b0000) begin
      for (int c = 0; c < 4; c++) if (g[c]) holder[k] = c;
      beats[k] = 1;
      e.d = data_in[holder[k]*8 +: 8];
      e.o = 2'(holder[k]);
      q_push(k, e);
    end
  endtask

  task automatic monitor_one(input int k);
    exp_t e;
    if (dut_oe(k)) begin
      if (prev_oe[k])
        chk(int'(dut_owner(k)) == prev_own[k], "adjacent_owner_change", k, int'(dut_owner(k)), prev_own[k]);
      chk(q_size(k) != 0, "unexpected_drive", k, 1, 0);
      if (q_size(k) != 0) begin
        e = q_pop(k);
        chk(dut_bus(k) === e.d, "bus_data", k, int'(dut_bus(k)), int'(e.d));
        chk(dut_owner(k) == e.o, "bus_owner", k, int'(dut_owner(k)), int'(e.o));
      end
    end else begin
      chk(q_size(k) == 0, "missing_drive", k, 0, 1);
      if (q_size(k) != 0) void'(q_pop(k));
    end
    prev_oe[k]  = dut_oe(k);
    prev_own[k] = int'(dut_owner(k));
  endtask

  always @(negedge Clk) begin
    if (Reset_n === 1'b1) begin
      for (int k = 0; k < ND; k++) monitor_one(k);
    end
  end

  task automatic do_cycle(input logic [3:0] r, input logic [31:0] d);
    @(posedge Clk);
    if (Reset_n) begin
      for (int k = 0; k < ND; k++) model_edge(k);
    end
    #1;
    req     = r;
    data_in = d;
    #1;
    for (int k = 0; k < ND; k++)
      chk(dut_gnt(k) == model_grant(k), "grant", k, int'(dut_gnt(k)), int'(model_grant(k)));
  endtask

  task automatic apply_reset(input int cyc, input logic [3:0] rel_req);
    req     = 4'($urandom);
    Reset_n = 1'b0;
    #1;
    for (int k = 0; k < ND; k++) begin
      chk(dut_oe(k) == 1'b0, "reset_bus_oe", k, int'(dut_oe(k)), 0);
      chk(dut_gnt(k) == 4'b0000, "reset_grant", k, int'(dut_gnt(k)), 0);
      chk(dut_owner(k) == 2'b00, "reset_owner", k, int'(dut_owner(k)), 0);
    end
    model_reset();
    repeat (cyc) @(posedge Clk);
    #1;
    req     = rel_req;
    Reset_n = 1'b1;
    #1;
    for (int k = 0; k < ND; k++)
      chk(dut_gnt(k) == model_grant(k), "grant_after_reset", k, int'(dut_gnt(k)), int'(model_grant(k)));
  endtask

  initial begin
    logic [7:0] v;
    logic [3:0] r;
    Reset_n = 1'b1;
    req     = 4'b0000;
    data_in = 32'h0;
    model_reset();
    #3;

    // Reset with random requests, then all request: ch0 must win first.
    apply_reset(2, 4'b1111);
    chk(grant_a == 4'b0001, "ch0_first_after_reset", 0, int'(grant_a), 1);
    chk(grant_c == 2'b01, "ch0_first_after_reset", 2, int'(grant_c), 1);
    repeat (3) do_cycle(4'b1111, $urandom);
    repeat (5) do_cycle(4'b0000, $urandom);

    // Single beat from ch2.
    do_cycle(4'b0100, 32'h00A5_0000);
    repeat (5) do_cycle(4'b0000, $urandom);

    // Ch1 held: data advances on each captured beat, burst cap forces release.
    v = 8'h01;
    for (int i = 0; i < 12; i++) begin
      do_cycle(4'b0010, {16'h0, v, 8'h0});
      if (grant_a[1]) v = v + 8'h01;
    end
    repeat (5) do_cycle(4'b0000, $urandom);

    // Everyone requests continuously: round-robin rotation.
    repeat (20) do_cycle(4'b1111, $urandom);
    repeat (5) do_cycle(4'b0000, $urandom);

    // Asynchronous reset between edges while ch2 drives.
    repeat (2) do_cycle(4'b0100, $urandom);
    chk(oe_a == 1'b1, "driving_before_reset", 0, int'(oe_a), 1);
    #1;
    apply_reset(1, 4'b1111);
    chk(grant_a == 4'b0001, "ch0_after_midburst_reset", 0, int'(grant_a), 1);
    repeat (4) do_cycle(4'b1111, $urandom);

    // Alternating two-channel requests.
    for (int i = 0; i < 16; i++) do_cycle((i % 2 == 0) ? 4'b0001 : 4'b0010, $urandom);
    repeat (4) do_cycle(4'b0011, $urandom);

    // Random traffic with sticky requests and occasional resets.
    r = 4'b0000;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 2) == 0) r = 4'($urandom);
      do_cycle(r, $urandom);
      if ($urandom_range(0, 149) == 0) begin
        #1;
        apply_reset(int'($urandom_range(1, 2)), 4'($urandom));
      end
    end
    repeat (8) do_cycle(4'b0000, $urandom);
    @(posedge Clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
